// File: rtl/threshold_cal_pkg.sv
// rtl/threshold_cal_pkg.sv - shared types and encodings for the threshold sweep calibrator
package threshold_cal_pkg;

    // Sweep controller phases
    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } cal_state_t;

    // Scoring mode encodings for the MODE parameter
    localparam int MODE_TRANSITIONS = 0;
    localparam int MODE_BALANCE     = 1;

endpackage

// File: rtl/frame_stat_counter.sv
// rtl/frame_stat_counter.sv - per-frame pixel, ones and horizontal-transition statistics
module frame_stat_counter
    import threshold_cal_pkg::*;
#(
    parameter int TOTAL  = 76800,
    parameter int CNT_W  = 17,
    parameter int STAT_W = 17
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              start,
    input  logic              line_start,
    input  logic              pixel,
    input  logic              pixel_valid,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [STAT_W-1:0] ones_cnt,
    output logic [STAT_W-1:0] trans_cnt
);

    localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] PIX_SAT  = CNT_W'(TOTAL + 1);

    logic have_prev;
    logic prev_pix;

    // Counters restart on start (with the start cycle's pixel), then accumulate while enabled.
    // ones/trans only accumulate over the first TOTAL pixels; anything longer is rejected
    // upstream anyway, and this keeps them from wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            pix_cnt   <= '0;
            ones_cnt  <= '0;
            trans_cnt <= '0;
            have_prev <= 1'b0;
            prev_pix  <= 1'b0;
        end else if (start) begin
            pix_cnt   <= pixel_valid ? CNT_W'(1) : '0;
            ones_cnt  <= (pixel_valid && pixel) ? STAT_W'(1) : '0;
            trans_cnt <= '0;
            have_prev <= pixel_valid;
            prev_pix  <= pixel;
        end else if (enable) begin
            if (line_start && !pixel_valid) begin
                have_prev <= 1'b0;
            end
            if (pixel_valid) begin
                if (pix_cnt != PIX_SAT) begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                end
                if (pix_cnt < PIX_FULL) begin
                    if (pixel) begin
                        ones_cnt <= ones_cnt + STAT_W'(1);
                    end
                    if (have_prev && !line_start && (pixel != prev_pix)) begin
                        trans_cnt <= trans_cnt + STAT_W'(1);
                    end
                end
                have_prev <= 1'b1;
                prev_pix  <= pixel;
            end
        end
    end

endmodule

// File: rtl/threshold_sweep_calibrator.sv
// rtl/threshold_sweep_calibrator.sv - sweeps dither thresholds over whole frames and locks the best-scoring one
module threshold_sweep_calibrator
    import threshold_cal_pkg::*;
#(
    parameter int H_PIXELS      = 320,
    parameter int V_LINES       = 240,
    parameter int THRESH_W      = 8,
    parameter int THRESH_MIN    = 0,
    parameter int THRESH_STEP   = 8,
    parameter int NUM_STEPS     = 32,
    parameter int SETTLE_FRAMES = 1,
    parameter int MODE          = 0,
    localparam int TOTAL        = H_PIXELS * V_LINES,
    localparam int SCORE_W      = $clog2(TOTAL + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    input  logic                line_start_in,
    input  logic                pixel_in,
    input  logic                pixel_valid_in,
    input  logic                recal_in,
    output logic [THRESH_W-1:0] threshold_out,
    output logic                calibrating_out,
    output logic                locked_out,
    output logic [SCORE_W-1:0]  best_score_out,
    output logic                frame_err_out
);

    localparam int CNT_W  = $clog2(TOTAL + 2);
    localparam int IDX_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SET_W  = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam int WIDE_W = SCORE_W + 1;

    localparam logic [THRESH_W-1:0] THR_FIRST = THRESH_W'(THRESH_MIN);
    localparam logic [THRESH_W-1:0] THR_INC   = THRESH_W'(THRESH_STEP);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_STEPS - 1);
    localparam logic [SET_W-1:0]    SET_INIT  = SET_W'(SETTLE_FRAMES);
    localparam logic [SET_W-1:0]    SET_AFTER = (SETTLE_FRAMES > 0) ? SET_W'(SETTLE_FRAMES - 1) : '0;
    localparam logic [CNT_W-1:0]    PIX_FULL  = CNT_W'(TOTAL);
    localparam logic [WIDE_W-1:0]   TOTAL_X   = WIDE_W'(TOTAL);

    // The last candidate must still fit in the threshold register
    if (THRESH_MIN + (NUM_STEPS - 1) * THRESH_STEP > (1 << THRESH_W) - 1) begin : g_range_check
        $error("threshold sweep range does not fit in THRESH_W bits");
    end

    cal_state_t           state;
    logic [SET_W-1:0]     settle_cnt;
    logic [IDX_W-1:0]     idx;
    logic [THRESH_W-1:0]  best_thresh;
    logic [SCORE_W-1:0]   best_score;

    logic [CNT_W-1:0]     pix_cnt;
    logic [SCORE_W-1:0]   ones_cnt;
    logic [SCORE_W-1:0]   trans_cnt;

    logic                 stat_clear;
    logic                 stat_start;
    logic                 stat_enable;
    logic [WIDE_W-1:0]    twice_ones;
    logic [WIDE_W-1:0]    imbalance;
    logic [WIDE_W-1:0]    score;
    logic                 frame_ok;
    logic                 new_best;

    // Counter control: restart on every frame boundary that opens a measured frame.
    // A frame_start coinciding with recal is discarded entirely.
    always_comb begin
        stat_clear  = rst_in || recal_in;
        stat_enable = (state == MEASURE);
        stat_start  = frame_start_in && !recal_in &&
                      (((state == SETTLE) && (settle_cnt == '0)) || (state == MEASURE));
    end

    frame_stat_counter #(
        .TOTAL  (TOTAL),
        .CNT_W  (CNT_W),
        .STAT_W (SCORE_W)
    ) u_stats (
        .clk         (clk_in),
        .clear       (stat_clear),
        .enable      (stat_enable),
        .start       (stat_start),
        .line_start  (line_start_in),
        .pixel       (pixel_in),
        .pixel_valid (pixel_valid_in),
        .pix_cnt     (pix_cnt),
        .ones_cnt    (ones_cnt),
        .trans_cnt   (trans_cnt)
    );

    // Score of the frame just closed; balance is TOTAL - |2*ones - TOTAL| kept one bit wider
    always_comb begin
        twice_ones = {ones_cnt, 1'b0};
        imbalance  = (twice_ones >= TOTAL_X) ? (twice_ones - TOTAL_X) : (TOTAL_X - twice_ones);
        if (MODE == MODE_BALANCE) begin
            score = TOTAL_X - imbalance;
        end else begin
            score = {1'b0, trans_cnt};
        end
        frame_ok = (pix_cnt == PIX_FULL);
        new_best = (score > {1'b0, best_score});
    end

    // Sweep controller: settle, measure and score each candidate, then lock the winner.
    // Recal re-runs the sweep but leaves the reported best score until a new frame is scored.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= SETTLE;
            settle_cnt      <= SET_INIT;
            idx             <= '0;
            threshold_out   <= THR_FIRST;
            best_thresh     <= THR_FIRST;
            best_score      <= '0;
            best_score_out  <= '0;
            calibrating_out <= 1'b1;
            locked_out      <= 1'b0;
            frame_err_out   <= 1'b0;
        end else if (recal_in) begin
            state           <= SETTLE;
            settle_cnt      <= SET_INIT;
            idx             <= '0;
            threshold_out   <= THR_FIRST;
            best_thresh     <= THR_FIRST;
            best_score      <= '0;
            calibrating_out <= 1'b1;
            locked_out      <= 1'b0;
            frame_err_out   <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            case (state)
                SETTLE: begin
                    if (frame_start_in) begin
                        if (settle_cnt != '0) begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    if (frame_start_in) begin
                        if (!frame_ok) begin
                            frame_err_out <= 1'b1;
                        end else begin
                            if (new_best) begin
                                best_score     <= score[SCORE_W-1:0];
                                best_thresh    <= threshold_out;
                                best_score_out <= score[SCORE_W-1:0];
                            end else begin
                                best_score_out <= best_score;
                            end
                            if (idx == IDX_LAST) begin
                                state           <= LOCKED;
                                threshold_out   <= new_best ? threshold_out : best_thresh;
                                calibrating_out <= 1'b0;
                                locked_out      <= 1'b1;
                            end else begin
                                idx           <= idx + IDX_W'(1);
                                threshold_out <= threshold_out + THR_INC;
                                if (SETTLE_FRAMES != 0) begin
                                    state      <= SETTLE;
                                    settle_cnt <= SET_AFTER;
                                end
                            end
                        end
                    end
                end
                LOCKED: begin
                end
                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_sweep_calibrator.sv
// tb/tb_threshold_sweep_calibrator.sv - self-checking bench for threshold_sweep_calibrator
module tb_threshold_sweep_calibrator;

    localparam int SW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, fs, ls, pv, recal;
    logic [4:0] pos;

    // pat[dut][candidate] holds the 32-pixel frame each DUT sees at that candidate threshold.
    // Dut0: MODE 0, settle 1. Dut1: MODE 1, settle 1. Dut2: MODE 0, settle 0.
    logic [31:0]   pat  [3][4];
    logic          pix  [3];
    logic [7:0]    thr  [3];
    logic          cal  [3];
    logic          lock [3];
    logic          err  [3];
    logic [SW-1:0] best [3];

    logic [7:0]    c_thr  [3];
    logic          c_cal  [3];
    logic          c_lock [3];
    logic          c_err  [3];
    logic [SW-1:0] c_best [3];

    int vectors = 0;
    int miscompares = 0;
    int err_seen [3];

    assign pix[0] = pat[0][thr[0][7:6]][pos];
    assign pix[1] = pat[1][thr[1][7:6]][pos];
    assign pix[2] = pat[2][thr[2][7:6]][pos];

    threshold_sweep_calibrator #(.H_PIXELS(8), .V_LINES(4), .THRESH_W(8), .THRESH_MIN(0),
        .THRESH_STEP(64), .NUM_STEPS(4), .SETTLE_FRAMES(1), .MODE(0)) dut0 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs), .line_start_in(ls),
        .pixel_in(pix[0]), .pixel_valid_in(pv), .recal_in(recal),
        .threshold_out(thr[0]), .calibrating_out(cal[0]), .locked_out(lock[0]),
        .best_score_out(best[0]), .frame_err_out(err[0]));

    threshold_sweep_calibrator #(.H_PIXELS(8), .V_LINES(4), .THRESH_W(8), .THRESH_MIN(0),
        .THRESH_STEP(64), .NUM_STEPS(4), .SETTLE_FRAMES(1), .MODE(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs), .line_start_in(ls),
        .pixel_in(pix[1]), .pixel_valid_in(pv), .recal_in(recal),
        .threshold_out(thr[1]), .calibrating_out(cal[1]), .locked_out(lock[1]),
        .best_score_out(best[1]), .frame_err_out(err[1]));

    threshold_sweep_calibrator #(.H_PIXELS(8), .V_LINES(4), .THRESH_W(8), .THRESH_MIN(0),
        .THRESH_STEP(64), .NUM_STEPS(4), .SETTLE_FRAMES(0), .MODE(0)) dut2 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs), .line_start_in(ls),
        .pixel_in(pix[2]), .pixel_valid_in(pv), .recal_in(recal),
        .threshold_out(thr[2]), .calibrating_out(cal[2]), .locked_out(lock[2]),
        .best_score_out(best[2]), .frame_err_out(err[2]));

    // Count every cycle each DUT reports a rejected frame
    always @(negedge clk) begin
        if (err[0] === 1'b1) err_seen[0]++;
        if (err[1] === 1'b1) err_seen[1]++;
        if (err[2] === 1'b1) err_seen[2]++;
    end

    // Reference scoring straight from the frame contents
    function automatic int model_score(input logic [31:0] p, input int mode);
        int t, ones, d;
        t = 0;
        ones = $countones(p);
        for (int l = 0; l < 4; l++)
            for (int x = 1; x < 8; x++)
                if (p[l*8 + x] != p[l*8 + x - 1]) t++;
        d = 2 * ones - 32;
        if (d < 0) d = -d;
        return (mode == 1) ? (32 - d) : t;
    endfunction

    // First candidate with the highest score, starting from best score 0 at candidate 0
    function automatic int model_win(input int k);
        int bs, bi, s;
        bs = 0; bi = 0;
        for (int c = 0; c < 4; c++) begin
            s = model_score(pat[k][c], (k == 1) ? 1 : 0);
            if (s > bs) begin bs = s; bi = c; end
        end
        return bi;
    endfunction

    function automatic int model_best(input int k);
        return model_score(pat[k][model_win(k)], (k == 1) ? 1 : 0);
    endfunction

    // Random frame with exactly n ones; pixel 0 is kept 0 because it is sampled in the
    // frame_start cycle, when a settle-less DUT is still presenting the previous threshold.
    function automatic logic [31:0] rand_pat(input int n);
        logic [31:0] p;
        p = '0;
        while ($countones(p) < n) p[$urandom_range(1, 31)] = 1'b1;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; fs = 1'b0; ls = 1'b0; pv = 1'b0; recal = 1'b0; pos = '0;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) err_seen[k] = 0;
    endtask

    // One frame of npix pixels with random idle gaps; outputs captured right after frame_start
    task automatic drive_frame(input int npix, input bit with_recal);
        for (int i = 0; i < npix; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                fs = 1'b0; ls = 1'b0; pv = 1'b0; recal = 1'b0;
                step();
            end
            fs = (i == 0); ls = (i % 8 == 0); pv = 1'b1;
            recal = with_recal && (i == 0);
            pos = 5'(i % 32);
            step();
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    c_thr[k] = thr[k]; c_cal[k] = cal[k]; c_lock[k] = lock[k];
                    c_err[k] = err[k]; c_best[k] = best[k];
                end
            end
        end
        fs = 1'b0; ls = 1'b0; pv = 1'b0; recal = 1'b0;
    endtask

    // Full sweep from reset, checking threshold/lock timing each frame and the final winner
    task automatic run_sweep(input string tag);
        int lim, win, et;
        do_reset();
        for (int j = 1; j <= 10; j++) begin
            drive_frame(32, 1'b0);
            for (int k = 0; k < 3; k++) begin
                lim = (k == 2) ? 5 : 9;
                win = model_win(k);
                if (j >= lim) et = win * 64;
                else if (k == 2) et = (j - 1) * 64;
                else et = ((j - 1) / 2) * 64;
                vectors++;
                if (c_thr[k] !== 8'(et)) begin
                    miscompares++;
                    $display("FAIL %s dut%0d frame %0d threshold got %0d want %0d", tag, k, j, c_thr[k], et);
                end
                vectors++;
                if (c_lock[k] !== (j >= lim) || c_cal[k] !== (j < lim)) begin
                    miscompares++;
                    $display("FAIL %s dut%0d frame %0d locked/calibrating got %b/%b want %b/%b",
                             tag, k, j, c_lock[k], c_cal[k], j >= lim, j < lim);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (best[k] !== SW'(model_best(k))) begin
                miscompares++;
                $display("FAIL %s dut%0d best_score got %0d want %0d", tag, k, best[k], model_best(k));
            end
            vectors++;
            if (err_seen[k] != 0) begin
                miscompares++;
                $display("FAIL %s dut%0d frame_err pulses got %0d want 0", tag, k, err_seen[k]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (thr[k] !== 8'd0 || cal[k] !== 1'b1 || lock[k] !== 1'b0 || best[k] !== '0 || err[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d thr=%0d cal=%b lock=%b best=%0d err=%b want 0/1/0/0/0",
                         k, thr[k], cal[k], lock[k], best[k], err[k]);
            end
        end
    endtask

    task automatic test_checkerboard();
        logic [31:0] cb;
        cb = '0;
        for (int p = 0; p < 32; p++) cb[p] = ((p / 8) + (p % 8)) % 2 == 1;
        for (int c = 0; c < 4; c++) begin
            pat[0][c] = (c == 2) ? cb : '0;
            pat[2][c] = (c == 2) ? cb : '0;
            pat[1][c] = (c == 3) ? rand_pat(16) : rand_pat(($urandom_range(0, 30) + 17) % 32 == 16 ? 15 : ($urandom_range(0, 30) >= 16 ? $urandom_range(17, 31) : $urandom_range(0, 15)));
        end
        run_sweep("checkerboard");
        vectors++;
        if (thr[0] !== 8'd128 || best[0] !== SW'(28) || thr[2] !== 8'd128 || best[2] !== SW'(28)) begin
            miscompares++;
            $display("FAIL checkerboard thr/best got %0d/%0d and %0d/%0d want 128/28", thr[0], best[0], thr[2], best[2]);
        end
        vectors++;
        if (thr[1] !== 8'd192 || best[1] !== SW'(32)) begin
            miscompares++;
            $display("FAIL balance thr/best got %0d/%0d want 192/32", thr[1], best[1]);
        end
    endtask

    task automatic test_ties();
        logic [31:0] p;
        for (int k = 0; k < 3; k++) begin
            p = rand_pat($urandom_range(4, 28));
            for (int c = 0; c < 4; c++) pat[k][c] = p;
        end
        run_sweep("ties");
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (thr[k] !== 8'd0) begin
                miscompares++;
                $display("FAIL ties dut%0d threshold got %0d want 0", k, thr[k]);
            end
        end
    endtask

    task automatic test_random_sweeps();
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 4; c++) pat[k][c] = rand_pat($urandom_range(0, 31));
            run_sweep("random");
        end
    endtask

    task automatic test_runt_frame();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) pat[k][c] = rand_pat($urandom_range(0, 31));
        do_reset();
        for (int j = 1; j <= 10; j++) begin
            drive_frame((j == 4) ? 31 : 32, 1'b0);
            if (j == 5) begin
                vectors++;
                if (c_err[0] !== 1'b1 || c_thr[0] !== 8'd64) begin
                    miscompares++;
                    $display("FAIL runt reject err/thr got %b/%0d want 1/64", c_err[0], c_thr[0]);
                end
            end
            if (j == 6) begin
                vectors++;
                if (c_err[0] !== 1'b0 || c_thr[0] !== 8'd128) begin
                    miscompares++;
                    $display("FAIL runt rescore err/thr got %b/%0d want 0/128", c_err[0], c_thr[0]);
                end
            end
        end
        vectors++;
        if (err_seen[0] != 1) begin
            miscompares++;
            $display("FAIL runt pulse count got %0d want 1", err_seen[0]);
        end
        vectors++;
        if (lock[0] !== 1'b1 || thr[0] !== 8'(model_win(0) * 64) || best[0] !== SW'(model_best(0))) begin
            miscompares++;
            $display("FAIL runt final lock/thr/best got %b/%0d/%0d want 1/%0d/%0d",
                     lock[0], thr[0], best[0], model_win(0) * 64, model_best(0));
        end
    endtask

    task automatic test_recal_mid_sweep();
        int s_old, s_new;
        logic [31:0] p;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) pat[k][c] = rand_pat($urandom_range(0, 31));
        s_old = model_score(pat[0][0], 0);
        do_reset();
        for (int j = 1; j <= 3; j++) drive_frame(32, 1'b0);
        vectors++;
        if (c_thr[0] !== 8'd64 || c_best[0] !== SW'(s_old)) begin
            miscompares++;
            $display("FAIL recal pre thr/best got %0d/%0d want 64/%0d", c_thr[0], c_best[0], s_old);
        end
        drive_frame(32, 1'b1);
        vectors++;
        if (c_thr[0] !== 8'd0 || c_cal[0] !== 1'b1 || c_lock[0] !== 1'b0 || c_best[0] !== SW'(s_old)) begin
            miscompares++;
            $display("FAIL recal apply thr/cal/lock/best got %0d/%b/%b/%0d want 0/1/0/%0d",
                     c_thr[0], c_cal[0], c_lock[0], c_best[0], s_old);
        end
        p = pat[0][0];
        for (int t = 0; t < 20 && model_score(p, 0) == s_old; t++) p = rand_pat($urandom_range(0, 31));
        pat[0][0] = p;
        s_new = model_score(p, 0);
        drive_frame(32, 1'b0);
        drive_frame(32, 1'b0);
        vectors++;
        if (c_thr[0] !== 8'd0 || c_best[0] !== SW'(s_old)) begin
            miscompares++;
            $display("FAIL recal settle thr/best got %0d/%0d want 0/%0d", c_thr[0], c_best[0], s_old);
        end
        drive_frame(32, 1'b0);
        vectors++;
        if (c_thr[0] !== 8'd64 || c_best[0] !== SW'(s_new)) begin
            miscompares++;
            $display("FAIL recal rescore thr/best got %0d/%0d want 64/%0d", c_thr[0], c_best[0], s_new);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            err_seen[k] = 0;
            for (int c = 0; c < 4; c++) pat[k][c] = '0;
        end
        test_reset();
        test_checkerboard();
        test_ties();
        test_random_sweeps();
        test_runt_frame();
        test_recal_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/threshold_sweep_calibrator.md
Name: threshold_sweep_calibrator

Overview:
- Selects the best binarisation threshold for the dither stage by sweeping NUM_STEPS candidate thresholds, one measured frame each, scoring every candidate, then locking the winner.
- Successor to the fixed-30-frame calibrator, adding:
  - parametrised frame geometry and threshold range;
  - frame-sync-driven boundaries;
  - settle frames after each threshold change;
  - two scoring modes, runt/overlong frame rejection, and an on-demand recalibration request.
- Sits between the dither pipeline output (1-bit pixel stream) and the dither stage's threshold input.

Parameters:
- H_PIXELS, 320, valid pixels per line.
- V_LINES, 240, lines per frame; TOTAL = H_PIXELS*V_LINES.
- THRESH_W, 8, threshold width.
- THRESH_MIN, 0, first candidate.
- THRESH_STEP, 8, increment between candidates.
- NUM_STEPS, 32, candidate count.
  - Elaboration assertion: THRESH_MIN + (NUM_STEPS-1)*THRESH_STEP <= 2^THRESH_W - 1.
- SETTLE_FRAMES, 1, whole frames discarded after each threshold change (covers dither pipeline latency).
- MODE, 0:
  - 0 = maximise horizontal transitions.
  - 1 = maximise black/white balance.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- frame_start_in  in  1  one-cycle pulse coincident with the first pixel slot of a frame
- line_start_in  in  1  one-cycle pulse coincident with the first pixel slot of a line
- pixel_in  in  1  dithered pixel
- pixel_valid_in  in  1  pixel_in qualifier
- recal_in  in  1  one-cycle recalibration request
- threshold_out  out  THRESH_W  threshold driven to dither stage (registered)
- calibrating_out  out  1  high while sweeping
- locked_out  out  1  high once winner applied
- best_score_out  out  SCORE_W  score of winner; SCORE_W = $clog2(TOTAL+1)
- frame_err_out  out  1  one-cycle pulse when a measured frame is rejected

Behaviour:
- Reset values:
  - state = SETTLE, settle_cnt = SETTLE_FRAMES, idx = 0.
  - threshold_out = THRESH_MIN, best threshold = THRESH_MIN.
  - best_score = 0, calibrating_out = 1, locked_out = 0, frame_err_out = 0.
  - All counters 0.
- Pixels before the first frame_start_in after reset or recal are ignored.
- SETTLE, on frame_start_in:
  - If settle_cnt > 0: decrement, stay in SETTLE.
  - If settle_cnt == 0: enter MEASURE; counters start with this cycle's pixel if valid.
- MEASURE, per valid pixel:
  - pix_cnt increments, saturating at TOTAL+1.
  - ones_cnt increments if pixel_in = 1.
  - trans_cnt increments if pixel_in != previous valid pixel of the same line.
  - The first valid pixel after line_start_in (or frame_start_in) is never counted as a transition; it only loads the previous-pixel register.
- Score:
  - MODE 0: score = trans_cnt.
  - MODE 1: score = TOTAL - |2*ones_cnt - TOTAL|, computed at SCORE_W+1 bits, no wrap.
- MEASURE, on frame_start_in (frame end and next frame start in the same cycle):
  - pix_cnt != TOTAL:
    - Pulse frame_err_out next cycle.
    - Candidate unchanged; counters restart with this frame; stay in MEASURE.
  - Otherwise:
    - If score > best_score (strict; ties keep the earlier, lower threshold), update best_score and best threshold.
    - If idx == NUM_STEPS-1:
      - Go to LOCKED; threshold_out <= winner (including a score updated this same cycle) next cycle.
      - calibrating_out = 0, locked_out = 1.
    - Else:
      - idx++, threshold_out += THRESH_STEP next cycle.
      - If SETTLE_FRAMES == 0: counters restart with this frame, stay in MEASURE.
      - Else: SETTLE with settle_cnt = SETTLE_FRAMES-1 (this frame is the first settle frame).
- LOCKED:
  - Outputs hold; pixel and sync inputs are ignored.
- recal_in (any state):
  - Next cycle: apply the reset values above (outputs included), except best_score_out. best_score_out holds its old value until the first measured frame completes, then tracks the new sweep.
  - If recal_in and frame_start_in coincide, recal wins and that frame_start_in is ignored.
- pixel_valid_in low: no counter activity.
- frame_start_in without line_start_in still clears the previous-pixel register.
- rst_in overrides recal_in.
- Latency: threshold changes exactly 1 cycle after the deciding frame_start_in.

Decomposition:
- Package threshold_cal_pkg holds:
  - state enum {SETTLE, MEASURE, LOCKED};
  - MODE encodings (MODE_TRANSITIONS = 0, MODE_BALANCE = 1).
- Sub-module frame_stat_counter: owns pix_cnt, ones_cnt, trans_cnt and the previous-pixel register, with a clear/start input and line-start handling.
- Sweep FSM and best-tracking stay in the top module.

Test Plan:
- Bench parameters throughout: H_PIXELS = 8, V_LINES = 4, THRESH_STEP = 64, NUM_STEPS = 4, SETTLE_FRAMES = 1, MODE 0.
1. Checkerboard stream only when threshold_out = 128, all-zeros otherwise -> locked_out rises 1 cycle after the 9th frame_start_in, threshold_out = 128, best_score_out = 28.
2. Identical scores for every candidate -> locks at threshold 0 (tie keeps earliest).
3. 31-pixel frame on candidate 64 -> frame_err_out pulses once, threshold_out stays 64, next full frame is scored.
4. MODE 1; candidate 192 gives 16 ones of 32 -> locks at 192, best_score_out = 32.
5. recal_in asserted in the same cycle as a frame_start_in mid-sweep -> next cycle threshold_out = 0, calibrating_out = 1, and that frame_start_in is not counted as a settle frame.
6. SETTLE_FRAMES = 0, repeat scenario 1 -> lock after the 5th frame_start_in, same threshold and score.
